// File: rtl/multicycle_cpu_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/WB sequencing,
// req/ack instruction fetch, internal register file, ALU and PC.
module multicycle_cpu_core #(
    parameter int          DATA_W   = 32,
    parameter int          REG_NUM  = 32,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ack_i,
    output logic        retire_o,
    output logic        illegal_o,
    output logic [31:0] pc_o
);
    localparam int IDX_W = $clog2(REG_NUM);
    localparam int SH_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              run;
    logic [31:0]       pc;
    logic [31:0]       ir;
    logic [31:0]       pc4;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] simm;
    logic [DATA_W-1:0] zimm;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] rf [REG_NUM];

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       shamt;
    logic [IDX_W-1:0] rs_idx;
    logic [IDX_W-1:0] rt_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_en;
    logic             illegal;
    logic             is_br;
    logic             is_j;
    logic             fetch_go;
    logic [31:0]      br_tgt;
    logic [31:0]      j_tgt;
    logic [31:0]      next_pc;

    assign opcode   = ir[31:26];
    assign funct    = ir[5:0];
    assign shamt    = ir[10:6];
    assign rs_idx   = ir[21 +: IDX_W];
    assign rt_idx   = ir[16 +: IDX_W];
    assign rd_idx   = ir[11 +: IDX_W];
    assign fetch_go = imem_req_o && imem_ack_i;

    assign br_tgt  = pc4 + {{14{ir[15]}}, ir[15:0], 2'b00};
    assign j_tgt   = {pc4[31:28], ir[25:0], 2'b00};
    assign next_pc = (is_br && alu_out[0]) ? br_tgt :
                     is_j ? j_tgt : pc4;

    assign imem_addr_o = pc;
    assign pc_o        = pc;

    // State register; run gates the first request until after reset
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state <= FETCH;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
        end
    end

    // Next-state and strobe outputs
    always_comb begin
        state_nxt  = state;
        imem_req_o = 1'b0;
        retire_o   = 1'b0;
        illegal_o  = 1'b0;
        unique case (state)
            FETCH: begin
                imem_req_o = run && rst_n;
                if (fetch_go) state_nxt = DECODE;
            end
            DECODE: state_nxt = EXEC;
            EXEC:   state_nxt = WB;
            WB: begin
                retire_o  = 1'b1;
                illegal_o = illegal;
                state_nxt = FETCH;
            end
        endcase
    end

    // Instruction decode: write target, control class, legality
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = rd_idx;
        illegal = 1'b0;
        is_br   = 1'b0;
        is_j    = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h27,
                    6'h2A, 6'h00, 6'h02, 6'h04, 6'h06:
                        wr_en = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            6'h08, 6'h0F: begin
                wr_en  = 1'b1;
                wr_idx = rt_idx;
            end
            6'h04, 6'h05: is_br = 1'b1;
            6'h02:        is_j  = 1'b1;
            default:      illegal = 1'b1;
        endcase
    end

    // Execute: ALU/shift result or branch condition in bit 0
    always_comb begin
        alu_res = '0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20: alu_res = op_a + op_b;
                    6'h22: alu_res = op_a - op_b;
                    6'h24: alu_res = op_a & op_b;
                    6'h25: alu_res = op_a | op_b;
                    6'h27: alu_res = ~(op_a | op_b);
                    6'h2A: alu_res[0] = $signed(op_a) < $signed(op_b);
                    6'h00: alu_res = op_b << shamt;
                    6'h02: alu_res = op_b >> shamt;
                    6'h04: alu_res = op_b << op_a[SH_W-1:0];
                    6'h06: alu_res = op_b >> op_a[SH_W-1:0];
                    default: alu_res = '0;
                endcase
            end
            6'h08: alu_res = op_a + simm;
            6'h0F: alu_res = zimm << 16;
            6'h04: alu_res[0] = (op_a == op_b);
            6'h05: alu_res[0] = (op_a != op_b);
            default: alu_res = '0;
        endcase
    end

    // Datapath registers advanced per state
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            pc      <= PC_RESET;
            ir      <= '0;
            pc4     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            simm    <= '0;
            zimm    <= '0;
            alu_out <= '0;
        end else begin
            unique case (state)
                FETCH: if (fetch_go) ir <= imem_rdata_i;
                DECODE: begin
                    op_a <= rf[rs_idx];
                    op_b <= rf[rt_idx];
                    simm <= {{(DATA_W-16){ir[15]}}, ir[15:0]};
                    zimm <= {{(DATA_W-16){1'b0}}, ir[15:0]};
                    pc4  <= pc + 32'd4;
                end
                EXEC: alu_out <= alu_res;
                WB:   pc <= next_pc;
            endcase
        end
    end

    // Register file write at the end of WB; entry 0 never written
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) rf[i] <= '0;
        end else if (state == WB && wr_en && wr_idx != '0) begin
            rf[wr_idx] <= alu_out;
        end
    end
endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Bench for multicycle_cpu_core: ISA-level model, random programs,
// random fetch wait states, directed programs with literal results.
module tb_multicycle_cpu_core;
    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i = '0;
    logic        imem_ack_i = 1'b0;
    logic        retire_o;
    logic        illegal_o;
    logic [31:0] pc_o;

    multicycle_cpu_core dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rdata_i (imem_rdata_i),
        .imem_ack_i   (imem_ack_i),
        .retire_o     (retire_o),
        .illegal_o    (illegal_o),
        .pc_o         (pc_o)
    );

    always #5 clk_i = ~clk_i;

    int          total = 0;
    int          bad = 0;
    logic [31:0] mem [64];
    logic [31:0] mregs [32];
    logic [31:0] mpc;
    bit          force_ack = 0;
    bit          rand_wait = 0;
    int          wait_n = 0;
    int          fetch_wait = 0;
    int          ill_cnt = 0;
    logic        rst_seen = 1'b0;

    always @(posedge clk_i) rst_seen <= rst_n;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_op(logic [5:0] fn, logic [4:0] rd,
                                         logic [4:0] rs, logic [4:0] rt,
                                         logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_op(logic [5:0] op, logic [4:0] rt,
                                         logic [4:0] rs, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_op(logic [25:0] t);
        return {6'h02, t};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mpc = 32'h0;
    endtask

    task automatic wr(input int idx, input logic [31:0] v);
        if (idx != 0) mregs[idx] = v;
    endtask

    // One architectural instruction at mpc
    task automatic model_step(output logic ill);
        logic [31:0] ins, a, b, se, npc;
        int rs, rt, rd;
        ins = mem[mpc[7:2]];
        rs = int'(ins[25:21]);
        rt = int'(ins[20:16]);
        rd = int'(ins[15:11]);
        a = mregs[rs];
        b = mregs[rt];
        se = {{16{ins[15]}}, ins[15:0]};
        npc = mpc + 32'd4;
        ill = 1'b0;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: wr(rd, a + b);
                6'h22: wr(rd, a - b);
                6'h24: wr(rd, a & b);
                6'h25: wr(rd, a | b);
                6'h27: wr(rd, ~(a | b));
                6'h2A: wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                6'h00: wr(rd, b << ins[10:6]);
                6'h02: wr(rd, b >> ins[10:6]);
                6'h04: wr(rd, b << a[4:0]);
                6'h06: wr(rd, b >> a[4:0]);
                default: ill = 1'b1;
            endcase
            6'h08: wr(rt, a + se);
            6'h0F: wr(rt, {ins[15:0], 16'h0000});
            6'h04: if (a == b) npc = npc + (se << 2);
            6'h05: if (a != b) npc = npc + (se << 2);
            6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            default: ill = 1'b1;
        endcase
        mpc = npc;
    endtask

    // Instruction memory responder with configurable wait states
    initial begin
        int cur_wait, wcnt;
        bit choosing;
        cur_wait = 0;
        wcnt = 0;
        choosing = 1;
        forever begin
            @(negedge clk_i);
            if (force_ack) begin
                imem_ack_i = 1'b1;
                imem_rdata_i = 32'hDEAD_BEEF;
            end else if (imem_req_o) begin
                if (choosing) begin
                    cur_wait = rand_wait ? int'($urandom_range(0, 3)) : wait_n;
                    wcnt = 0;
                    choosing = 0;
                end
                if (wcnt >= cur_wait) begin
                    imem_ack_i = 1'b1;
                    imem_rdata_i = mem[imem_addr_o[7:2]];
                    fetch_wait = wcnt;
                    choosing = 1;
                end else begin
                    imem_ack_i = 1'b0;
                    wcnt++;
                end
            end else begin
                imem_ack_i = 1'b0;
                choosing = 1;
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        bit pend, prev_req, prev_ret, lvalid;
        logic [31:0] prev_addr;
        longint cyc, last_cyc;
        logic exp_ill;
        pend = 0; prev_req = 0; prev_ret = 0; lvalid = 0;
        prev_addr = '0; cyc = 0; last_cyc = 0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!rst_seen) begin
                check("rst_req", imem_req_o, 0);
                check("rst_retire", retire_o, 0);
                check("rst_illegal", illegal_o, 0);
                check("rst_pc", pc_o, 32'h0);
                model_reset();
                pend = 0; prev_req = 0; prev_ret = 0; lvalid = 0;
            end else begin
                if (pend) begin
                    check("pc_next", pc_o, mpc);
                    for (int i = 0; i < 32; i++)
                        check($sformatf("reg%0d", i), dut.rf[i], mregs[i]);
                    pend = 0;
                end
                if (imem_req_o) begin
                    if (prev_req) check("addr_stable", imem_addr_o, prev_addr);
                    else check("fetch_addr", imem_addr_o, mpc);
                    prev_addr = imem_addr_o;
                end
                prev_req = imem_req_o;
                if (retire_o) begin
                    check("retire_pulse", prev_ret, 0);
                    check("retire_pc", pc_o, mpc);
                    if (lvalid) check("cpi", cyc - last_cyc, 4 + fetch_wait);
                    lvalid = 1;
                    last_cyc = cyc;
                    model_step(exp_ill);
                    check("illegal", illegal_o, exp_ill);
                    if (illegal_o) ill_cnt++;
                    pend = 1;
                end else begin
                    check("illegal_idle", illegal_o, 0);
                end
                prev_ret = retire_o;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = '0;
    endtask

    task automatic reset_core(input int n);
        @(posedge clk_i);
        #1 rst_n = 1'b0;
        force_ack = 1;
        repeat (n) @(posedge clk_i);
        #1 rst_n = 1'b1;
        force_ack = 0;
    endtask

    task automatic run_ret(input int n, output int cycles);
        int got;
        got = 0;
        cycles = 0;
        while (got < n && cycles < 400 * n) begin
            @(negedge clk_i);
            cycles++;
            if (retire_o) got++;
        end
        check("retire_timeout", got, n);
    endtask

    task automatic load_prog_a();
        clear_mem();
        mem[0] = i_op(6'h08, 1, 0, 16'd5);
        mem[1] = i_op(6'h08, 2, 0, 16'hFFFD);
        mem[2] = r_op(6'h20, 3, 1, 2, 0);
        mem[3] = r_op(6'h2A, 4, 2, 1, 0);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [5:0] fns [10];
        logic [4:0] rs, rt, rd, sh;
        logic [15:0] imm;
        int k, off;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27,
                6'h2A, 6'h00, 6'h02, 6'h04, 6'h06};
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        sh = 5'($urandom);
        imm = 16'($urandom);
        k = int'($urandom_range(0, 14));
        off = int'($urandom_range(0, 8)) - 4;
        if (k < 10) return r_op(fns[k], rd, rs, rt, sh);
        if (k == 10) return i_op(6'h08, rt, rs, imm);
        if (k == 11) return i_op(6'h0F, rt, rs, imm);
        if (k == 12) return i_op($urandom_range(0, 1) ? 6'h04 : 6'h05,
                                 rt, rs, off[15:0]);
        if (k == 13) return j_op(26'($urandom_range(0, 63)));
        if ($urandom_range(0, 1) == 1) return {6'h3F, 26'($urandom)};
        return r_op(6'h3F, rd, rs, rt, sh);
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        // Reset with ack held high, then zero-wait arithmetic
        load_prog_a();
        reset_core(3);
        @(negedge clk_i);
        check("rst_reg3", dut.rf[3], 0);
        run_ret(4, c);
        @(negedge clk_i);
        check("A_r3", dut.rf[3], 32'd2);
        check("A_r4", dut.rf[4], 32'd1);
        check("A_pc", pc_o, 32'h10);
        check("A_model_r3", mregs[3], 32'd2);

        // Shifts and lui
        clear_mem();
        mem[0] = i_op(6'h08, 1, 0, 16'h00F0);
        mem[1] = i_op(6'h08, 5, 0, 16'd4);
        mem[2] = r_op(6'h00, 6, 0, 1, 5'd4);
        mem[3] = r_op(6'h06, 7, 5, 1, 0);
        mem[4] = i_op(6'h0F, 8, 0, 16'h1234);
        reset_core(2);
        run_ret(5, c);
        @(negedge clk_i);
        check("B_sll", dut.rf[6], 32'h0000_0F00);
        check("B_srlv", dut.rf[7], 32'h0000_000F);
        check("B_lui", dut.rf[8], 32'h1234_0000);

        // Branches, jump and $0 writes
        clear_mem();
        mem[0]  = i_op(6'h08, 1, 0, 16'd7);
        mem[1]  = j_op(26'h8);
        mem[8]  = i_op(6'h04, 1, 1, 16'd2);
        mem[11] = i_op(6'h08, 0, 0, 16'd9);
        mem[12] = i_op(6'h05, 1, 1, 16'd2);
        mem[13] = j_op(26'h10);
        mem[16] = i_op(6'h08, 9, 0, 16'd1);
        reset_core(2);
        run_ret(3, c);
        @(negedge clk_i);
        check("C_beq_pc", pc_o, 32'h2C);
        run_ret(2, c);
        @(negedge clk_i);
        check("C_bne_pc", pc_o, 32'h34);
        check("C_r0", dut.rf[0], 0);
        run_ret(1, c);
        @(negedge clk_i);
        check("C_j_pc", pc_o, 32'h40);

        clear_mem();
        mem[0] = j_op(26'h8);
        mem[8] = i_op(6'h05, 1, 1, 16'd2);
        reset_core(2);
        run_ret(2, c);
        @(negedge clk_i);
        check("C2_bne_pc", pc_o, 32'h24);

        // Three wait states per fetch
        load_prog_a();
        wait_n = 3;
        reset_core(2);
        run_ret(1, c);
        run_ret(1, c);
        check("D_cpi", c, 7);
        run_ret(2, c);
        @(negedge clk_i);
        check("D_r3", dut.rf[3], 32'd2);
        check("D_r4", dut.rf[4], 32'd1);
        check("D_pc", pc_o, 32'h10);
        wait_n = 0;

        // Reset while add is in EXEC
        load_prog_a();
        reset_core(2);
        run_ret(2, c);
        repeat (3) @(posedge clk_i);
        #1 rst_n = 1'b0;
        force_ack = 1;
        repeat (2) @(posedge clk_i);
        #1 rst_n = 1'b1;
        force_ack = 0;
        @(negedge clk_i);
        check("E_r3", dut.rf[3], 0);
        check("E_r1", dut.rf[1], 0);
        run_ret(4, c);
        @(negedge clk_i);
        check("E_r3_after", dut.rf[3], 32'd2);
        check("E_pc", pc_o, 32'h10);

        // Illegal opcode and funct
        clear_mem();
        mem[0] = i_op(6'h08, 1, 0, 16'd5);
        mem[1] = i_op(6'h08, 2, 0, 16'd6);
        mem[2] = i_op(6'h3F, 3, 1, 16'h0001);
        mem[3] = r_op(6'h3F, 3, 1, 2, 0);
        reset_core(2);
        ill_cnt = 0;
        run_ret(4, c);
        @(negedge clk_i);
        check("F_ill_cnt", ill_cnt, 2);
        check("F_r3", dut.rf[3], 0);
        check("F_r1", dut.rf[1], 32'd5);
        check("F_pc", pc_o, 32'h10);

        // Random programs with random wait states
        rand_wait = 1;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 64; i++) mem[i] = rand_ins();
            reset_core(2);
            run_ret(150, c);
            @(negedge clk_i);
        end
        rand_wait = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
